cordic_rr_arb: RTL and testbench

CORDIC_RR_ARB -- requirements
Module: cordic_rr_arb

---
 rtl/cordic_rr_arb.sv | 162 ++++++++++++++++
 tb/tb_cordic_rr_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_arb.sv
// cordic_rr_arb: three requesters share one in-order CORDIC engine; a DEPTH-entry tag FIFO routes results back.
// Issue and return are combinational. Issue stalls at DEPTH in flight, results stall on res_rdy. CORDIC_ARB_FIXED_PRI_EN selects fixed priority.

module cordic_rr_arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module cordic_rr_arb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      req_theta0,
  input  logic [DATA_W-1:0]      req_theta1,
  input  logic [DATA_W-1:0]      req_theta2,
  input  logic [2:0]             req_vld,
  output logic [2:0]             req_rdy,
  output logic [DATA_W-1:0]      eng_theta,
  output logic                   eng_vld,
  input  logic                   eng_rdy,
  input  logic [DATA_W-1:0]      eng_res_i,
  input  logic [DATA_W-1:0]      eng_res_r,
  input  logic                   eng_res_vld,
  output logic                   eng_res_rdy,
  output logic [DATA_W-1:0]      res_i,
  output logic [DATA_W-1:0]      res_r,
  output logic [1:0]             res_tag,
  output logic                   res_vld,
  input  logic                   res_rdy,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0] grant;
  logic [1:0] head_tag;
  logic       issue;
  logic       fifo_empty;
  logic       pop;

`ifdef CORDIC_ARB_FIXED_PRI_EN
  always_comb begin
    grant = 2'd0;
    if (req_vld[0])      grant = 2'd0;
    else if (req_vld[1]) grant = 2'd1;
    else if (req_vld[2]) grant = 2'd2;
  end
`else
  logic [1:0] last_gnt;

  // Search starts one past the last winner; reset value 2 gives requester 0 first turn.
  always_comb begin
    grant = 2'd0;
    case (last_gnt)
      2'd0: begin
        if (req_vld[1])      grant = 2'd1;
        else if (req_vld[2]) grant = 2'd2;
        else                 grant = 2'd0;
      end
      2'd1: begin
        if (req_vld[2])      grant = 2'd2;
        else if (req_vld[0]) grant = 2'd0;
        else if (req_vld[1]) grant = 2'd1;
      end
      default: begin
        if (req_vld[0])      grant = 2'd0;
        else if (req_vld[1]) grant = 2'd1;
        else if (req_vld[2]) grant = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        last_gnt <= 2'd2;
    else if (issue) last_gnt <= grant;
  end
`endif

  // Registered count only: a same-cycle pop never frees a slot for a push.
  assign eng_vld = (|req_vld) && (outstanding < DEPTH_C);
  assign issue   = eng_vld && eng_rdy;
  assign req_rdy = issue ? (3'b001 << grant) : 3'b000;

  always_comb begin
    eng_theta = '0;
    if (eng_vld) begin
      case (grant)
        2'd0:    eng_theta = req_theta0;
        2'd1:    eng_theta = req_theta1;
        default: eng_theta = req_theta2;
      endcase
    end
  end

  assign fifo_empty  = (outstanding == '0);
  assign res_vld     = eng_res_vld;
  assign eng_res_rdy = res_rdy;
  assign res_i       = eng_res_i;
  assign res_r       = eng_res_r;
  assign res_tag     = fifo_empty ? 2'd0 : head_tag;
  assign pop         = eng_res_vld && res_rdy && !fifo_empty;

  // A result with no matching tag means the engine and arbiter disagree; latch it.
  always_ff @(posedge clk) begin
    if (rst)                             err_orphan <= 1'b0;
    else if (eng_res_vld && fifo_empty)  err_orphan <= 1'b1;
  end

  cordic_rr_arb_tag_fifo #(
    .W     (2),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_dat (grant),
    .pop      (pop),
    .head_dat (head_tag),
    .count    (outstanding)
  );
endmodule

// File: tb/tb_cordic_rr_arb.sv
// Bench for cordic_rr_arb: issue table, full-FIFO turnaround, in-order tag return, orphan detection and reset.
module tb_cordic_rr_arb;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
`ifdef CORDIC_ARB_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] req_theta0, req_theta1, req_theta2;
  logic [2:0]        req_vld, req_rdy;
  logic [DATA_W-1:0] eng_theta;
  logic              eng_vld, eng_rdy;
  logic [DATA_W-1:0] eng_res_i, eng_res_r;
  logic              eng_res_vld, eng_res_rdy;
  logic [DATA_W-1:0] res_i, res_r;
  logic [1:0]        res_tag;
  logic              res_vld, res_rdy;
  logic [3:0]        outstanding;
  logic              err_orphan;

  always #5 clk = ~clk;

  cordic_rr_arb #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_theta0(req_theta0), .req_theta1(req_theta1), .req_theta2(req_theta2),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .eng_theta(eng_theta), .eng_vld(eng_vld), .eng_rdy(eng_rdy),
    .eng_res_i(eng_res_i), .eng_res_r(eng_res_r),
    .eng_res_vld(eng_res_vld), .eng_res_rdy(eng_res_rdy),
    .res_i(res_i), .res_r(res_r), .res_tag(res_tag),
    .res_vld(res_vld), .res_rdy(res_rdy),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [2:0] req;
    logic       erdy;
    logic       exp_vld;
    logic [1:0] exp_gnt;
    int         exp_out;
  } vec_t;

  vec_t       vecs[11];
  logic [1:0] tag_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic apply_row(input vec_t v, input int idx);
    logic [DATA_W-1:0] th [3];
    logic [DATA_W-1:0] exp_th;
    logic [2:0]        exp_rdy;
    for (int k = 0; k < 3; k++) th[k] = $urandom;
    req_theta0 = th[0];
    req_theta1 = th[1];
    req_theta2 = th[2];
    req_vld    = v.req;
    eng_rdy    = v.erdy;
    #1;
    exp_rdy = (v.exp_vld && v.erdy) ? (3'b001 << v.exp_gnt) : 3'b000;
    exp_th  = v.exp_vld ? th[v.exp_gnt] : '0;
    chk($sformatf("row%0d eng_vld", idx), 64'(eng_vld), 64'(v.exp_vld));
    chk($sformatf("row%0d req_rdy", idx), 64'(req_rdy), 64'(exp_rdy));
    chk($sformatf("row%0d eng_theta", idx), 64'(eng_theta), 64'(exp_th));
    if (exp_rdy != 3'b000) tag_q.push_back(v.exp_gnt);
    @(posedge clk); #1;
    chk($sformatf("row%0d outstanding", idx), 64'(outstanding), 64'(v.exp_out));
    @(negedge clk);
  endtask

  task automatic issue_one(input logic [2:0] req, input logic [1:0] gnt, input string name);
    req_vld = req;
    eng_rdy = 1'b1;
    #1;
    chk({name, " req_rdy"}, 64'(req_rdy), 64'(3'b001 << gnt));
    tag_q.push_back(gnt);
    @(posedge clk); #1;
    chk({name, " outstanding"}, 64'(outstanding), 64'(tag_q.size()));
    @(negedge clk);
    req_vld = 3'b000;
  endtask

  // Returns n results with res_rdy following 1,0,1,1 repeating.
  task automatic drain(input int n, input string name);
    logic [3:0] pat = 4'b1101;
    logic       rr;
    int         done = 0;
    int         cyc = 0;
    while (done < n && cyc < 4 * n + 4) begin
      rr          = pat[cyc % 4];
      eng_res_vld = 1'b1;
      eng_res_i   = $urandom;
      eng_res_r   = $urandom;
      res_rdy     = rr;
      #1;
      chk($sformatf("%s c%0d res_vld", name, cyc), 64'(res_vld), 64'(1'b1));
      chk($sformatf("%s c%0d eng_res_rdy", name, cyc), 64'(eng_res_rdy), 64'(rr));
      chk($sformatf("%s c%0d res_i", name, cyc), 64'(res_i), 64'(eng_res_i));
      chk($sformatf("%s c%0d res_r", name, cyc), 64'(res_r), 64'(eng_res_r));
      chk($sformatf("%s c%0d res_tag", name, cyc), 64'(res_tag), 64'(tag_q[0]));
      if (rr) begin
        void'(tag_q.pop_front());
        done++;
      end
      @(posedge clk); #1;
      chk($sformatf("%s c%0d outstanding", name, cyc), 64'(outstanding), 64'(tag_q.size()));
      @(negedge clk);
      cyc++;
    end
    chk({name, " returned"}, 64'(done), 64'(n));
    eng_res_vld = 1'b0;
    res_rdy     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b111, 1'b1, 1'b1, 2'd0, 1};
    vecs[1]  = '{3'b111, 1'b1, 1'b1, FIXED_PRI ? 2'd0 : 2'd1, 2};
    vecs[2]  = '{3'b111, 1'b1, 1'b1, FIXED_PRI ? 2'd0 : 2'd2, 3};
    vecs[3]  = '{3'b111, 1'b1, 1'b1, 2'd0, 4};
    vecs[4]  = '{3'b111, 1'b1, 1'b1, FIXED_PRI ? 2'd0 : 2'd1, 5};
    vecs[5]  = '{3'b111, 1'b1, 1'b1, FIXED_PRI ? 2'd0 : 2'd2, 6};
    vecs[6]  = '{3'b101, 1'b0, 1'b1, 2'd0, 6};
    vecs[7]  = '{3'b110, 1'b1, 1'b1, 2'd1, 7};
    vecs[8]  = '{3'b000, 1'b1, 1'b0, 2'd0, 7};
    vecs[9]  = '{3'b001, 1'b1, 1'b1, 2'd0, 8};
    vecs[10] = '{3'b111, 1'b1, 1'b0, 2'd0, 8};

    rst = 1'b1;
    req_vld = 3'b111;
    eng_rdy = 1'b1;
    req_theta0 = '0; req_theta1 = '0; req_theta2 = '0;
    eng_res_i = '0; eng_res_r = '0; eng_res_vld = 1'b0; res_rdy = 1'b0;

    // Reset state, and grant logic live on reset-value state.
    @(posedge clk); @(negedge clk); #1;
    chk("reset req_rdy", 64'(req_rdy), 64'(3'b001));
    chk("reset outstanding", 64'(outstanding), 64'd0);
    chk("reset err_orphan", 64'(err_orphan), 64'd0);
    @(posedge clk); #1;
    chk("reset issue not recorded", 64'(outstanding), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_vld = 3'b000;

    for (int i = 0; i < 11; i++) apply_row(vecs[i], i);

    // Full FIFO: a pop does not unblock a push in the same cycle.
    req_vld     = 3'b111;
    eng_rdy     = 1'b1;
    eng_res_vld = 1'b1;
    res_rdy     = 1'b1;
    eng_res_i   = $urandom;
    eng_res_r   = $urandom;
    #1;
    chk("full eng_vld", 64'(eng_vld), 64'd0);
    chk("full req_rdy", 64'(req_rdy), 64'd0);
    chk("full res_tag", 64'(res_tag), 64'(tag_q[0]));
    chk("full res_i", 64'(res_i), 64'(eng_res_i));
    void'(tag_q.pop_front());
    @(posedge clk); #1;
    chk("full pop outstanding", 64'(outstanding), 64'd7);
    @(negedge clk);
    eng_res_vld = 1'b0;
    res_rdy     = 1'b0;
    issue_one(3'b111, FIXED_PRI ? 2'd0 : 2'd1, "refill");
    chk("refill outstanding", 64'(outstanding), 64'd8);

    drain(8, "drain8");

    issue_one(3'b100, 2'd2, "seq tag2");
    issue_one(3'b001, 2'd0, "seq tag0");
    issue_one(3'b010, 2'd1, "seq tag1");
    drain(3, "ret201");

    // Orphan result: flag sets and sticks, count stays at zero.
    eng_res_vld = 1'b1;
    res_rdy     = 1'b1;
    eng_res_i   = $urandom;
    #1;
    chk("orphan res_vld", 64'(res_vld), 64'd1);
    chk("orphan res_tag", 64'(res_tag), 64'd0);
    chk("orphan err before edge", 64'(err_orphan), 64'd0);
    @(posedge clk); #1;
    chk("orphan err set", 64'(err_orphan), 64'd1);
    chk("orphan outstanding", 64'(outstanding), 64'd0);
    @(negedge clk);
    eng_res_vld = 1'b0;
    res_rdy     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("orphan sticky %0d", i), 64'(err_orphan), 64'd1);
    end
    @(negedge clk);

    // Reset with ops in flight discards their tags.
    issue_one(3'b001, 2'd0, "pre-reset a");
    issue_one(3'b001, 2'd0, "pre-reset b");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst err_orphan", 64'(err_orphan), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tag_q.delete();
    eng_res_vld = 1'b1;
    res_rdy     = 1'b1;
    #1;
    chk("post-reset res_tag", 64'(res_tag), 64'd0);
    @(posedge clk); #1;
    chk("post-reset orphan", 64'(err_orphan), 64'd1);
    chk("post-reset outstanding", 64'(outstanding), 64'd0);
    @(negedge clk);
    eng_res_vld = 1'b0;
    res_rdy     = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
